// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the wishbone-to-SRAM RAM controllers:
// data/select widths, controller FSM states and interconnect bus records.
package ram_ctrl_pkg;

  localparam int unsigned RAM_DATA_BITS = 64;
  localparam int unsigned RAM_SEL_BITS  = 8;
  localparam int unsigned WB_ADR_BITS   = 29;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [RAM_SEL_BITS-1:0]  sel;
    logic [WB_ADR_BITS-1:0]   adr;
    logic [RAM_DATA_BITS-1:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic [RAM_DATA_BITS-1:0] dat;
    logic                     ack;
    logic                     stall;
  } wb_rsp_t;

endpackage

// File: rtl/ram512_wb_ctrl_if.sv
// Pipelined wishbone bus between the interconnect (master) and a RAM
// controller (slave).
interface ram512_wb_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADR_BITS = 29
) ();

  logic                     wb_cyc;
  logic                     wb_stb;
  logic                     wb_we;
  logic [RAM_SEL_BITS-1:0]  wb_sel;
  logic [ADR_BITS-1:0]      wb_adr;
  logic [RAM_DATA_BITS-1:0] wb_dat_w;
  logic [RAM_DATA_BITS-1:0] wb_dat_r;
  logic                     wb_ack;
  logic                     wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    input  wb_dat_r, wb_ack, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    output wb_dat_r, wb_ack, wb_stall
  );

endinterface

// File: rtl/ram512_wb_ctrl.sv
// Wishbone pipelined slave driving one 512x64 byte-writable SRAM port.
// Each accepted strobe becomes a single-cycle SRAM access; the ack follows
// one cycle later and carries the SRAM's registered read data.
// Optional macro RAM512_CLEAR_EN: after reset, zero every word of the SRAM
// (bus stalled) before entering normal operation.
module ram512_wb_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned BITS     = 9,
  parameter int unsigned ADR_BITS = 29
) (
  input  logic                     CLK,
  input  logic                     RST,
  ram512_wb_ctrl_if.slave          wb,
  output logic                     ram_en,
  output logic [RAM_SEL_BITS-1:0]  ram_we,
  output logic [BITS-1:0]          ram_a,
  output logic [RAM_DATA_BITS-1:0] ram_di,
  input  logic [RAM_DATA_BITS-1:0] ram_do
);

  logic            w_acc;
  logic            w_stall;
  logic            w_clear;
  logic [BITS-1:0] w_clr_a;
  logic            r_pend;
  logic            w_unused_adr;

  // Upper doubleword address bits alias onto the same SRAM words.
  assign w_unused_adr = ^wb.wb_adr[ADR_BITS-1:BITS];

`ifdef RAM512_CLEAR_EN
  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_cnt;

  // FSM state register: reset always restarts the clear sweep.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // Clear address counter, advancing once per clear cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     r_cnt <= '0;
    else if (r_state == ST_CLEAR) r_cnt <= r_cnt + BITS'(1);
  end

  // Next state: leave CLEAR after the last word has been written.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_clear = 1'b1;
      if (r_cnt == '1) w_state_nxt = ST_RUN;
    end
  end

  assign w_clr_a = r_cnt;
`else
  assign w_clear = 1'b0;
  assign w_clr_a = '0;
`endif

  assign w_stall     = w_clear;
  assign wb.wb_stall = w_stall;
  assign w_acc       = wb.wb_cyc & wb.wb_stb & ~w_stall;

  // SRAM port drive: clear sweep or the accepted request, idle under reset.
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = wb.wb_adr[BITS-1:0];
    ram_di = wb.wb_dat_w;
    if (w_clear) begin
      ram_a  = w_clr_a;
      ram_di = '0;
    end
    if (!RST) begin
      if (w_clear) begin
        ram_en = 1'b1;
        ram_we = '1;
      end else if (w_acc) begin
        ram_en = 1'b1;
        if (wb.wb_we) ram_we = wb.wb_sel;
      end
    end
  end

  // Ack-pending flag: one per accepted request, dropped by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pend <= 1'b0;
    else     r_pend <= w_acc;
  end

  // Dropping wb_cyc in the ack cycle aborts the ack, not the SRAM access.
  assign wb.wb_ack   = r_pend & wb.wb_cyc;
  assign wb.wb_dat_r = wb.wb_ack ? ram_do : '0;

endmodule

// File: tb/tb_ram512_wb_ctrl.sv
// Self-checking bench for ram512_wb_ctrl with a behavioural SRAM macro.
// Build with RAM512_CLEAR_EN defined to exercise the post-reset clear sweep.
module tb_ram512_wb_ctrl;
  import ram_ctrl_pkg::*;

  localparam int unsigned BITS     = 9;
  localparam int unsigned ADR_BITS = 29;
  localparam int unsigned DEPTH    = 512;
`ifdef RAM512_CLEAR_EN
  localparam logic [63:0] PRELOAD = {8{8'hAA}};
`else
  localparam logic [63:0] PRELOAD = '0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [8:0]  ram_a;
  logic [63:0] ram_di;
  logic [63:0] ram_do = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram512_wb_ctrl_if #(.ADR_BITS(ADR_BITS)) bus ();

  ram512_wb_ctrl #(.BITS(BITS), .ADR_BITS(ADR_BITS)) dut (
    .CLK    (clk),
    .RST    (rst),
    .wb     (bus.slave),
    .ram_en (ram_en),
    .ram_we (ram_we),
    .ram_a  (ram_a),
    .ram_di (ram_di),
    .ram_do (ram_do)
  );

  // SRAM macro: byte-write, registered read, zero output when not enabled.
  logic [63:0] sram [DEPTH];
  bit          pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= PRELOAD;
      pre_done <= 1'b1;
      ram_do   <= '0;
    end else if (ram_en) begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) sram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= sram[ram_a];
    end else begin
      ram_do <= '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory contents and the one outstanding request.
  logic [63:0] mm [DEPTH];
  bit          m_pend = 1'b0;
  bit          m_pend_rd = 1'b0;
  logic [63:0] m_rdat = '0;
  initial for (int i = 0; i < DEPTH; i++) mm[i] = '0;

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    bit         acc;
    bit         exp_ack;
    logic [8:0] a;
    if (chk_en) begin
      acc = bus.wb_cyc && bus.wb_stb;
      a   = bus.wb_adr[8:0];
      chk("stall", bus.wb_stall, 0);
      chk("ram_en", ram_en, (!rst && acc) ? 1 : 0);
      chk("ram_we", ram_we, (!rst && acc && bus.wb_we) ? bus.wb_sel : 8'h00);
      if (!rst && acc) begin
        chk("ram_a", ram_a, a);
        chk("ram_di", ram_di, bus.wb_dat_w);
      end
      exp_ack = m_pend && bus.wb_cyc && !rst;
      chk("wb_ack", bus.wb_ack, exp_ack);
      if (!exp_ack)       chk("dat_r_idle", bus.wb_dat_r, 0);
      else if (m_pend_rd) chk("dat_r", bus.wb_dat_r, m_rdat);
      m_pend    = acc && !rst;
      m_pend_rd = !bus.wb_we;
      m_rdat    = mm[a];
      if (acc && !rst && bus.wb_we)
        for (int b = 0; b < 8; b++)
          if (bus.wb_sel[b]) mm[a][8*b +: 8] = bus.wb_dat_w[8*b +: 8];
    end
  end

  task automatic drive(input bit cyc, input bit stb, input bit we, input logic [7:0] sel,
                       input logic [28:0] adr, input logic [63:0] dat);
    bus.wb_cyc   = cyc;
    bus.wb_stb   = stb;
    bus.wb_we    = we;
    bus.wb_sel   = sel;
    bus.wb_adr   = adr;
    bus.wb_dat_w = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [28:0] adr, input logic [7:0] sel, input logic [63:0] dat);
    drive(1, 1, 1, sel, adr, dat);
    tick();
  endtask

  task automatic rd_check(input logic [28:0] adr, input logic [63:0] exp, input string nm);
    drive(1, 1, 0, 8'hFF, adr, '0);
    tick();
    drive(1, 0, 0, 8'h00, '0, '0);
    @(negedge clk);
    chk({nm, "_ack"}, bus.wb_ack, 1);
    chk(nm, bus.wb_dat_r, exp);
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 8'h00, '0, '0);
    rst = 1'b1;
`ifndef RAM512_CLEAR_EN
    chk_en = 1'b1;
`endif
    tick();
    @(negedge clk);
    chk("reset_ack", bus.wb_ack, 0);
    chk("reset_en", ram_en, 0);
    chk("reset_we", ram_we, 0);
    tick();
    rst = 1'b0;

`ifdef RAM512_CLEAR_EN
    begin
      int n = 0;
      int acks = 0;
      drive(1, 1, 0, 8'hFF, 29'd3, '0);
      while (n < 600) begin
        @(negedge clk);
        if (bus.wb_ack) acks++;
        if (!bus.wb_stall) break;
        n++;
      end
      chk("clear_cycles", n, 512);
      chk("clear_no_ack", acks, 0);
      drive(0, 0, 0, 8'h00, '0, '0);
      tick();
      tick();
      chk_en = 1'b1;
      rd_check(29'd511, 64'h0, "clear_rd511");
    end
`endif

    // Full-word write then read.
    drive(1, 1, 1, 8'hFF, 29'd5, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("w5_we", ram_we, 8'hFF);
    tick();
    rd_check(29'd5, 64'h0123456789ABCDEF, "rd5");

    // Partial byte write over zero.
    wr(29'd7, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
    rd_check(29'd7, 64'h00000000FFFFFFFF, "rd7");

    // Back-to-back writes then back-to-back reads.
    for (int i = 0; i < 4; i++) wr(29'(i), 8'hFF, {16{4'(i + 1)}});
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1, 1, 0, 8'hFF, 29'(i), '0);
      else       drive(1, 0, 0, 8'h00, '0, '0);
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_ack", bus.wb_ack, 1);
        chk("b2b_dat", bus.wb_dat_r, {16{4'(i)}});
      end
      chk("b2b_stall", bus.wb_stall, 0);
      tick();
    end

    // Abort: cyc drops in the ack cycle.
    drive(1, 1, 0, 8'hFF, 29'd5, '0);
    tick();
    drive(0, 0, 0, 8'h00, '0, '0);
    @(negedge clk);
    chk("abort_ack", bus.wb_ack, 0);
    tick();
    rd_check(29'd5, 64'h0123456789ABCDEF, "rd5_again");

    // Upper address bits alias; address 511 is an ordinary word.
    wr(29'h0010_01FF, 8'hFF, 64'hDEADBEEFCAFEF00D);
    rd_check(29'd511, 64'hDEADBEEFCAFEF00D, "alias511");
    rd_check(29'd0, 64'h1111111111111111, "wrap0");

    // Read immediately after write to the same word.
    wr(29'd9, 8'hFF, 64'h5555555555555555);
    rd_check(29'd9, 64'h5555555555555555, "raw9");

    // Zero byte selects: write changes nothing, read returns the full word.
    drive(1, 1, 1, 8'h00, 29'd9, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    chk("wsel0_en", ram_en, 1);
    chk("wsel0_we", ram_we, 0);
    tick();
    drive(1, 1, 0, 8'h00, 29'd9, '0);
    @(negedge clk);
    chk("wsel0_ack", bus.wb_ack, 1);
    tick();
    drive(1, 0, 0, 8'h00, '0, '0);
    @(negedge clk);
    chk("rsel0_ack", bus.wb_ack, 1);
    chk("rsel0_dat", bus.wb_dat_r, 64'h5555555555555555);
    tick();

    // Reset right after a read accept; a write strobed during reset is ignored.
    drive(1, 1, 0, 8'hFF, 29'd3, '0);
    tick();
    rst = 1'b1;
    drive(1, 1, 1, 8'hFF, 29'd3, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    chk("rst_ack", bus.wb_ack, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    tick();
    rst = 1'b0;
`ifdef RAM512_CLEAR_EN
    chk_en = 1'b0;
    drive(0, 0, 0, 8'h00, '0, '0);
`else
    drive(1, 0, 0, 8'h00, '0, '0);
    @(negedge clk);
    chk("rst_noack", bus.wb_ack, 0);
    tick();
    rd_check(29'd3, 64'h4444444444444444, "rd3_after_rst");
    drive(0, 0, 0, 8'h00, '0, '0);
`endif
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram512_wb_ctrl.md
Name: ram512_wb_ctrl

Overview:
- Wishbone pipelined slave that drives one 512x64 byte-writable SRAM macro port: enable, byte write enables, address, write data, registered read data.
- Sits between the Microwatt wishbone interconnect and each on-chip RAM macro instance.
- Converts wishbone strobes into single-cycle SRAM accesses and generates ordered acks and read data.

Parameters:
- BITS, 9, SRAM word-address width (depth = 2**BITS 64-bit words).
- ADR_BITS, 29, wishbone doubleword address width; only bits [BITS-1:0] reach the SRAM, upper bits ignored.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- wb_cyc  in  1  bus cycle active.
- wb_stb  in  1  request strobe.
- wb_we  in  1  1 = write, 0 = read.
- wb_sel  in  8  byte selects; bit i covers data[8i+7:8i].
- wb_adr  in  ADR_BITS  doubleword address.
- wb_dat_w  in  64  write data.
- wb_dat_r  out  64  read data, valid when wb_ack=1.
- wb_ack  out  1  one-cycle acknowledge per accepted request.
- wb_stall  out  1  request not accepted this cycle.
- ram_en  out  1  SRAM enable.
- ram_we  out  8  SRAM byte write enables.
- ram_a  out  BITS  SRAM word address.
- ram_di  out  64  SRAM write data.
- ram_do  in  64  SRAM read data; registered in SRAM, valid the cycle after ram_en, zero otherwise.

Behaviour:
- Reset (RST=1, async): wb_ack=0, ack-pending register=0. ram_en=0 and ram_we=0 forced while RST=1.
- Accept condition: acc = wb_cyc & wb_stb & ~wb_stall.
- Issue, same cycle, combinational:
  - ram_en = acc
  - ram_we = wb_sel when acc & wb_we, else 0
  - ram_a = wb_adr[BITS-1:0]
  - ram_di = wb_dat_w
- Read with wb_sel=0: still asserts ram_en, still acked, returns the full word.
- Write with wb_sel=0: ram_en=1, ram_we=0, acked.
- Ack: registered. wb_ack(t+1) = acc(t) & wb_cyc(t+1). Latency is exactly 1 cycle for reads and writes.
- Throughput: back-to-back accepts every cycle. wb_stall=0 in RUN state.
- Read data: wb_dat_r = ram_do when wb_ack=1, else 64'b0. No extra register.
- Abort: wb_cyc dropping in the cycle after an accept suppresses that ack. A write already issued remains committed.
- Address wrap: word 2**BITS-1 followed by 0 needs no special handling; upper address bits alias.
- Simultaneous read-after-write, same address, consecutive cycles: the read returns the new data (the SRAM sequences write then read on separate edges).
- FSM: RUN only when the optional feature is absent. With it present: RST → CLEAR → RUN.
- RST asserted mid-operation: pending ack dropped immediately. No ack is produced for that in-flight request.

Optional Feature:
- Macro RAM512_CLEAR_EN.
- When defined, after RST deasserts the FSM is in CLEAR:
  - wb_stall=1.
  - Each cycle drives ram_en=1, ram_we=8'hFF, ram_di=0, ram_a=counter.
  - Counter increments from 0 up to 2**BITS-1, then the FSM moves to RUN.
  - Exactly 2**BITS clear cycles; wb_stall falls on cycle 2**BITS after reset release.
  - Requests during CLEAR are not accepted and produce no ack.
  - RST during CLEAR restarts the counter at 0.
- When undefined: no counter, FSM starts in RUN, wb_stall tied 0.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - constants RAM_DATA_BITS=64 and RAM_SEL_BITS=8
  - FSM state enum (ST_CLEAR, ST_RUN)
  - wishbone request/response struct typedefs matching the interconnect.
- No sub-module is needed; the clear sequencer is an inline counter under the macro.

Test Plan:
- Write adr=5, sel=FF, dat=0x0123456789ABCDEF, then read adr=5 → ram_we=FF in the write cycle; read ack one cycle later with wb_dat_r=0x0123456789ABCDEF.
- Write adr=7, sel=0x0F, dat=0xFFFFFFFFFFFFFFFF over prior 0 → read returns 0x00000000FFFFFFFF.
- Four back-to-back reads adr=0..3, stb held high → four consecutive acks, data in order, wb_stall=0 throughout.
- Read accepted, wb_cyc dropped the next cycle → wb_ack stays 0; a later read of the same address acks normally.
- RST pulsed the cycle after a read accept → no ack; wb_ack=0 and ram_en=0 while RST=1.
- RAM512_CLEAR_EN, SRAM preloaded with 0xAA.. → wb_stall high for 512 cycles after reset; then read adr=511 returns 0.
